// File: rtl/rr_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter_pkg
// Description : Shared types, default sizes and index helper for the
//               round-robin register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_reg_arbiter_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_DATA_W  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Circular successor of a requester index.
    function automatic int next_idx(input int idx, input int num_req);
        return (idx >= num_req - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter_if
// Description : Requester-side bus and shared-register outputs of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         q;
    logic                      q_valid;
    logic [IDX_W-1:0]          owner;
    logic                      locked;

    modport master (
        output req, lock, wdata,
        input  gnt, q, q_valid, owner, locked
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, q_valid, owner, locked
    );

endinterface
`default_nettype wire

// File: rtl/rr_reg_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Circular priority encoder; first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_gnt,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_any
);

    logic [IDX_W:0]   r_unused_sum;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i folded back into 0..NUM_REQ-1 without a modulo operator
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_j = IDX_W'(w_sum);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

    assign r_unused_sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter writing one granted lane per cycle into a
//               shared register, with a per-requester lock for bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int DATA_W  = C_DATA_W
) (
    input wire logic      clk,
    input wire logic      rst,
    rr_reg_arbiter_if.slave bus
);

    localparam int                 IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [DATA_W-1:0]  r_q;
    logic               r_q_valid;

    state_e             w_state_next;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [DATA_W-1:0]  w_lane [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_gnt        = '0;
        w_grant      = 1'b0;
        w_idx        = r_owner;
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        w_gnt   = w_pick_gnt;
                        w_grant = 1'b1;
                        w_idx   = w_pick_idx;
                    end
                end
                LOCKED: begin
                    if (bus.req[r_owner]) begin
                        w_gnt   = c_one << r_owner;
                        w_grant = 1'b1;
                    end
                end
                default: ;
            endcase
            // Leaving a burst (or a plain grant) hands priority to the next index.
            if (w_grant && bus.lock[w_idx]) begin
                w_state_next = LOCKED;
            end else if (w_grant || r_state == LOCKED) begin
                w_state_next = IDLE;
                w_ptr_next   = IDX_W'(next_idx(int'(w_idx), NUM_REQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_q_valid <= w_grant;
            if (w_grant) begin
                r_q     <= w_lane[w_idx];
                r_owner <= w_idx;
            end
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.owner   = r_owner;
    assign bus.locked  = (r_state == LOCKED);

endmodule
`default_nettype wire
